mfp_multi_input_debouncer: RTL and testbench
============================================

MFP_MULTI_INPUT_DEBOUNCER -- requirements
Module: mfp_multi_input_debouncer

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth per channel (minimum 2).
REQ-003 SHALL have parameter DEBOUNCE, default 500000, stable-cycle count before a level change is accepted (minimum 1).
REQ-004 SHALL have parameter INVERT, default all-zero WIDTH-bit mask; a set bit marks an active-low input channel.
REQ-005 SHALL have parameter RESET_VALUE, default all-zero WIDTH-bit vector, post-invert debounced level after reset.
REQ-006 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset; synchronous and active-low.
REQ-008 SHALL have port sw_in  input  WIDTH  raw switch/button levels, asynchronous to clk.
REQ-009 SHALL have port sw_out  output  WIDTH  debounced, inversion-corrected level, registered.
REQ-010 SHALL have port sw_rise  output  WIDTH  one-cycle pulse per channel when sw_out goes 0->1.
REQ-011 SHALL have port sw_fall  output  WIDTH  one-cycle pulse per channel when sw_out goes 1->0.
REQ-012 SHALL have port sw_changed  output  1  one-cycle pulse, OR-reduce of sw_rise|sw_fall.
REQ-013 SHALL have port sw_busy  output  WIDTH  per-channel flag, high while that channel's counter is non-zero.

Function
REQ-014 Each channel SHALL pass sw_in[i] XOR INVERT[i] through a SYNC_STAGES flop chain; the last stage is "synced[i]".
REQ-015 Each channel SHALL own a counter of width $clog2(DEBOUNCE)+1; counters are independent, with no shared state.
REQ-016 If synced[i] == sw_out[i], counter[i] SHALL clear to 0 on the next edge (glitch abort).
REQ-017 If synced[i] != sw_out[i] and counter[i] < DEBOUNCE-1, counter[i] SHALL increment by 1.
REQ-018 If synced[i] != sw_out[i] and counter[i] == DEBOUNCE-1, then on that same edge: sw_out[i] <= synced[i], counter[i] <= 0, and the matching rise/fall bit SHALL be set.
REQ-019 sw_rise, sw_fall and sw_changed SHALL be registered and high for exactly one cycle per accepted transition; no outputs are combinational from sw_in.
REQ-020 Total latency SHALL be: a raw change stable before edge E0 is seen on sw_out after edge E(SYNC_STAGES+DEBOUNCE-1).
REQ-021 The counter SHALL never exceed DEBOUNCE-1 and SHALL never wrap.
REQ-022 Simultaneous accepted transitions on several channels SHALL assert all matching sw_rise/sw_fall bits in the same cycle, with a single-cycle sw_changed.
REQ-023 With DEBOUNCE==1, a change SHALL be accepted on the first edge at which synced differs from sw_out.
REQ-024 sw_busy[i] SHALL equal (counter[i] != 0), registered with the counter.

Reset
REQ-025 While resetn==0 at a clock edge: all synchroniser stages SHALL load RESET_VALUE, sw_out SHALL load RESET_VALUE, counters SHALL load 0, and sw_rise, sw_fall, sw_changed and sw_busy SHALL load 0.
REQ-026 Reset asserted mid-count SHALL discard the pending transition with no pulse; after release, a full REQ-020 latency SHALL be required.
REQ-027 The first cycle after reset release SHALL NOT produce a pulse, even if sw_in (post-invert) differs from RESET_VALUE; such a difference is debounced normally.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=4, INVERT=4'b0010, RESET_VALUE=0 unless stated)
REQ-028 Raw sw_in[0] 0->1 held stable -> sw_out[0]=1 after the 6th edge (E5), sw_rise[0]=1 and sw_changed=1 for that single cycle, sw_busy[0] high during E2..E4.
REQ-029 sw_in[0] high for 3 cycles then low -> sw_out[0] stays 0, no pulses, counter returns to 0.
REQ-030 Out of reset with sw_in[1]=1 (inverted) -> sw_out[1] stays 0; sw_in[1] 1->0 -> sw_out[1]=1 at E5 with sw_rise[1] pulse.
REQ-031 sw_in[0] and sw_in[2] rise in the same cycle -> both sw_out bits update at the same edge, sw_rise=4'b0101 for one cycle, single-cycle sw_changed.
REQ-032 resetn pulsed low for one cycle when counter[0]==2 -> no pulse and sw_out[0]=0; after release with sw_in[0] still 1, sw_out[0]=1 exactly 6 edges later.
REQ-033 DEBOUNCE=1 build: sw_in[3] 0->1 -> sw_out[3]=1 after the 3rd edge (E2) with sw_rise[3] pulse; 1->0 gives sw_fall[3] with the same latency.

Source files
------------

// File: rtl/mfp_multi_input_debouncer.sv
// mfp_multi_input_debouncer
//   Multi-channel switch/button debouncer. Each channel has its own
//   inversion, synchroniser chain and stable-cycle counter. A level change
//   is accepted only after the synchronised input has disagreed with the
//   debounced level for DEBOUNCE consecutive edges.
//
// Ports
//   clk        : system clock, all state on rising edge
//   resetn     : synchronous active-low reset
//   sw_in      : raw switch levels (asynchronous to clk)
//   sw_out     : debounced, inversion-corrected level (registered)
//   sw_rise    : one-cycle pulse per channel on accepted 0->1
//   sw_fall    : one-cycle pulse per channel on accepted 1->0
//   sw_changed : one-cycle pulse when any channel accepted a change
//   sw_busy    : per-channel, high while that channel's counter is non-zero

module mfp_debounce_lane #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 500000,
    parameter logic INVERT      = 1'b0,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy,
    output logic o_accept
);
    localparam int             CW   = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    logic                   w_synced;
    logic                   w_differ;
    logic                   w_accept;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_synced != r_level);
    // Final stable cycle: the change is taken on this same edge.
    assign w_accept = w_differ && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Synchroniser is preloaded so the first cycles after release
            // see the reset level and cannot fake a transition.
            r_sync  <= {SYNC_STAGES{RESET_VALUE}};
            r_level <= RESET_VALUE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw ^ INVERT};
            r_rise <= w_accept & w_synced;
            r_fall <= w_accept & ~w_synced;
            if (!w_differ) begin
                // Glitch abort: input returned to current level.
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else if (w_accept) begin
                r_level <= w_synced;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_busy <= 1'b1;
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_busy   = r_busy;
    assign o_accept = w_accept;
endmodule

module mfp_multi_input_debouncer #(
    parameter int               WIDTH       = 10,
    parameter int               SYNC_STAGES = 2,
    parameter int               DEBOUNCE    = 500000,
    parameter logic [WIDTH-1:0] INVERT      = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_busy
);
    logic [WIDTH-1:0] w_accept;
    logic             r_changed;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        mfp_debounce_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .INVERT      (INVERT[g]),
            .RESET_VALUE (RESET_VALUE[g])
        ) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .i_raw    (sw_in[g]),
            .o_level  (sw_out[g]),
            .o_rise   (sw_rise[g]),
            .o_fall   (sw_fall[g]),
            .o_busy   (sw_busy[g]),
            .o_accept (w_accept[g])
        );
    end

    // Registered from the same accept terms as the per-lane pulses so it
    // lines up with sw_rise/sw_fall and stays a single cycle wide.
    always_ff @(posedge clk) begin
        if (!resetn) r_changed <= 1'b0;
        else         r_changed <= |w_accept;
    end

    assign sw_changed = r_changed;
endmodule

// File: tb/tb_mfp_multi_input_debouncer.sv
module tb_mfp_multi_input_debouncer;
    localparam int         W    = 4;
    localparam int         S    = 2;
    localparam logic [3:0] INV  = 4'b0010;
    localparam logic [3:0] RV   = 4'b0000;
    localparam logic [3:0] IDLE = 4'b0010;   // raw level giving all-zero post-invert
    localparam int         MAXE = 4096;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] sw_in = IDLE;

    logic [3:0] out4, rise4, fall4, busy4, out1, rise1, fall1, busy1;
    logic       chg4, chg1;
    logic [16:0] got4, got1, exp4, exp1;

    assign got4 = {out4, rise4, fall4, chg4, busy4};
    assign got1 = {out1, rise1, fall1, chg1, busy1};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mfp_multi_input_debouncer #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(4),
        .INVERT(INV), .RESET_VALUE(RV)) dut4 (
        .clk(clk), .resetn(resetn), .sw_in(sw_in), .sw_out(out4),
        .sw_rise(rise4), .sw_fall(fall4), .sw_changed(chg4), .sw_busy(busy4));

    mfp_multi_input_debouncer #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE(1),
        .INVERT(INV), .RESET_VALUE(RV)) dut1 (
        .clk(clk), .resetn(resetn), .sw_in(sw_in), .sw_out(out1),
        .sw_rise(rise1), .sw_fall(fall1), .sw_changed(chg1), .sw_busy(busy1));

    // Reference: per-edge history of post-invert inputs and resets.
    logic [3:0] inp [MAXE];
    bit         rstv[MAXE];
    logic [3:0] o4  [MAXE];
    logic [3:0] o1  [MAXE];
    int         ne = 0;

    // Synchronised level seen just before edge n: the input sampled S edges
    // earlier, unless a reset inside that span forced the reset level.
    function automatic logic [3:0] syn_at(input int n);
        if (n - S < 0) return RV;
        for (int m = n - S; m < n; m++) if (rstv[m]) return RV;
        return inp[n-S];
    endfunction

    // Accept at edge n when the last d edges (none of them a reset) all saw
    // the synchronised level disagree with the level held before edge n.
    function automatic logic [16:0] model(input int n, input int d, input logic [3:0] prev);
        logic [3:0] o, r, f, b, s, sn;
        logic acc;
        if (rstv[n]) return {RV, 13'd0};
        sn = syn_at(n);
        for (int ch = 0; ch < W; ch++) begin
            acc = 1'b1;
            for (int k = 0; k < d; k++) begin
                if (n - k < 0) acc = 1'b0;
                else if (rstv[n-k]) acc = 1'b0;
                else begin
                    s = syn_at(n - k);
                    if (s[ch] == prev[ch]) acc = 1'b0;
                end
            end
            o[ch] = acc ? ~prev[ch] : prev[ch];
            b[ch] = !acc && (sn[ch] != prev[ch]);
        end
        r = o & ~prev;
        f = ~o & prev;
        return {o, r, f, |(r | f), b};
    endfunction

    task automatic step(input logic rn, input logic [3:0] raw);
        logic [3:0] p4, p1;
        if (ne >= MAXE) begin
            $display("FAIL edge_budget exceeded at %0d edges, limit %0d", ne, MAXE);
            $fatal(1);
        end
        @(negedge clk);
        resetn = rn;
        sw_in  = raw;
        @(posedge clk);
        inp[ne]  = raw ^ INV;
        rstv[ne] = !rn;
        p4 = (ne == 0) ? RV : o4[ne-1];
        p1 = (ne == 0) ? RV : o1[ne-1];
        exp4 = model(ne, 4, p4);
        exp1 = model(ne, 1, p1);
        o4[ne] = exp4[16:13];
        o1[ne] = exp1[16:13];
        ne++;
        #1;
    endtask

    task automatic test_reset();
        for (int e = 0; e < 3; e++) begin
            step(1'b0, IDLE);
            n_vec++;
            if (got4 !== 17'd0) begin
                n_bad++; $display("FAIL reset dut4 e=%0d got=%h exp=%h", e, got4, 17'd0);
            end
            n_vec++;
            if (got1 !== 17'd0) begin
                n_bad++; $display("FAIL reset dut1 e=%0d got=%h exp=%h", e, got1, 17'd0);
            end
        end
        step(1'b1, IDLE);
        n_vec++;
        if (got4 !== exp4) begin
            n_bad++; $display("FAIL reset_release dut4 got=%h exp=%h", got4, exp4);
        end
    endtask

    task automatic test_single_rise();
        for (int e = 0; e < 8; e++) begin
            step(1'b1, 4'b0011);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL single_rise dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if ({out4[0], rise4[0], chg4, busy4[0]} !== {e >= 5, e == 5, e == 5, e >= 2 && e <= 4}) begin
                n_bad++;
                $display("FAIL single_rise_latency e=%0d got out/rise/chg/busy=%b%b%b%b", e, out4[0], rise4[0], chg4, busy4[0]);
            end
        end
        for (int e = 0; e < 8; e++) begin
            step(1'b1, IDLE);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL single_fall dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if (fall4[0] !== (e == 5)) begin
                n_bad++; $display("FAIL single_fall_pulse e=%0d got=%b exp=%b", e, fall4[0], e == 5);
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 0; e < 11; e++) begin
            step(1'b1, (e < 3) ? 4'b0011 : IDLE);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL glitch dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if ({out4[0], rise4[0], chg4} !== 3'b000) begin
                n_bad++; $display("FAIL glitch_nopulse e=%0d got=%b exp=000", e, {out4[0], rise4[0], chg4});
            end
        end
        n_vec++;
        if (busy4[0] !== 1'b0) begin
            n_bad++; $display("FAIL glitch_counter_idle got=%b exp=0", busy4[0]);
        end
    endtask

    task automatic test_invert();
        step(1'b0, IDLE);
        for (int e = 0; e < 3; e++) begin
            step(1'b1, IDLE);
            n_vec++;
            if (out4[1] !== 1'b0) begin
                n_bad++; $display("FAIL invert_idle e=%0d got=%b exp=0", e, out4[1]);
            end
        end
        for (int e = 0; e < 7; e++) begin
            step(1'b1, 4'b0000);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL invert dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if ({out4[1], rise4[1]} !== {e >= 5, e == 5}) begin
                n_bad++; $display("FAIL invert_rise e=%0d got=%b%b", e, out4[1], rise4[1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1'b0, IDLE);
        step(1'b1, IDLE);
        for (int e = 0; e < 7; e++) begin
            step(1'b1, 4'b0111);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL simultaneous dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if ({rise4, chg4} !== ((e == 5) ? 5'b0101_1 : 5'b0000_0)) begin
                n_bad++; $display("FAIL simultaneous_rise e=%0d got=%b%b", e, rise4, chg4);
            end
        end
        n_vec++;
        if (out4 !== 4'b0101) begin
            n_bad++; $display("FAIL simultaneous_level got=%b exp=0101", out4);
        end
        for (int e = 0; e < 8; e++) step(1'b1, IDLE);
    endtask

    task automatic test_reset_midcount();
        step(1'b0, IDLE);
        step(1'b1, IDLE);
        for (int e = 0; e < 4; e++) step(1'b1, 4'b0011);   // counter[0] reaches 2
        n_vec++;
        if (busy4[0] !== 1'b1) begin
            n_bad++; $display("FAIL midcount_busy got=%b exp=1", busy4[0]);
        end
        step(1'b0, 4'b0011);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 4'b0011);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL midcount dut4 k=%0d got=%h exp=%h", k, got4, exp4);
            end
            n_vec++;
            if ({out4[0], rise4[0]} !== {k >= 6, k == 6}) begin
                n_bad++; $display("FAIL midcount_latency k=%0d got=%b%b", k, out4[0], rise4[0]);
            end
        end
        for (int e = 0; e < 8; e++) step(1'b1, IDLE);
    endtask

    task automatic test_debounce1();
        step(1'b0, IDLE);
        step(1'b1, IDLE);
        for (int e = 0; e < 4; e++) begin
            step(1'b1, 4'b1010);
            n_vec++;
            if (got1 !== exp1) begin
                n_bad++; $display("FAIL deb1_rise dut1 e=%0d got=%h exp=%h", e, got1, exp1);
            end
            n_vec++;
            if ({out1[3], rise1[3]} !== {e >= 2, e == 2}) begin
                n_bad++; $display("FAIL deb1_rise_latency e=%0d got=%b%b", e, out1[3], rise1[3]);
            end
        end
        for (int e = 0; e < 4; e++) begin
            step(1'b1, IDLE);
            n_vec++;
            if ({out1[3], fall1[3]} !== {e < 2, e == 2}) begin
                n_bad++; $display("FAIL deb1_fall_latency e=%0d got=%b%b", e, out1[3], fall1[3]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] raw;
        logic       rn;
        raw = IDLE;
        for (int e = 0; e < 600; e++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
            rn = ($urandom_range(0, 59) != 0);
            step(rn, raw);
            n_vec++;
            if (got4 !== exp4) begin
                n_bad++; $display("FAIL random dut4 e=%0d got=%h exp=%h", e, got4, exp4);
            end
            n_vec++;
            if (got1 !== exp1) begin
                n_bad++; $display("FAIL random dut1 e=%0d got=%h exp=%h", e, got1, exp1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_invert();
        test_simultaneous();
        test_reset_midcount();
        test_debounce1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
